vga_text_console: RTL
=====================

Name: vga_text_console

Overview:
- Character-stream front end for the VGA text VRAM. Accepts one byte at a time over a valid/ready handshake and keeps a hardware cursor.
- Turns each byte into Wishbone master write cycles to the VGA block's text-data window (ADR 15'b01+index) and text-colour window (ADR 15'b10+index).
- Sequences line wrap, row clear and full-screen clear, so the CPU no longer computes VRAM addresses.
- Sits between a CPU-side UART/console register and the VGA Wishbone slave.

Parameters:
COLS, 80, text columns per row
ROWS, 60, text rows per screen
IDX_W, 13, cell index width (COLS*ROWS-1 must fit)
CLEAR_CHAR, 8'h20, byte written to data VRAM when clearing
INIT_CLEAR, 0, 1 = perform a full-screen clear automatically after reset

Ports:
CLK_I  in  1  system clock; single clock domain
RST_I  in  1  reset, synchronous, active-high
char_valid  in  1  byte offered
char_data  in  8  byte value
char_ready  out  1  byte accepted when char_valid&char_ready at a rising edge
colour_in  in  8  colour attribute; sampled together with each accepted byte
busy  out  1  high whenever state != IDLE
cursor_col  out  7  current column, 0..COLS-1
cursor_row  out  6  current row, 0..ROWS-1
ADR_O  out  15  Wishbone address: {2'b01,idx} for data, {2'b10,idx} for colour
DAT_O  out  8  Wishbone write data
CYC_O  out  1  Wishbone cycle
STB_O  out  1  Wishbone strobe
WE_O  out  1  Wishbone write enable; always 1 while STB_O=1
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Reset (RST_I=1 at an edge):
  - State goes to IDLE (or CLR_SCREEN if INIT_CLEAR=1); cursor 0,0.
  - ADR_O=0, DAT_O=0, CYC_O=STB_O=WE_O=0.
  - char_ready=0 while RST_I=1.
  - Reset mid-transfer drops STB/CYC at that edge; no further writes are issued.
- char_ready = (state==IDLE) & ~RST_I. Accepting a byte latches char_data and colour_in.
- Cell index: idx = row*COLS + col, IDX_W bits, registered.
- States: IDLE, WR_DATA, WR_COL, ADVANCE, CLR_DATA, CLR_COL, CLR_NEXT, CLR_SCREEN.
- Byte decode on accept (next state):
  - 0x0D CR: col=0 -> IDLE. No bus traffic.
  - 0x08 BS: col = col-1, saturating at 0 -> IDLE. No bus traffic.
  - 0x0A LF: col=0, row advance (see below) -> CLR_DATA for the new row.
  - 0x0C FF: cursor=0,0 -> CLR_SCREEN, which clears all COLS*ROWS cells starting at idx 0.
  - Any other byte: WR_DATA (DAT_O=byte, ADR_O={2'b01,idx}), then WR_COL (DAT_O=latched colour, ADR_O={2'b10,idx}), then ADVANCE.
- Bus transfer rules:
  - STB_O/CYC_O/WE_O are asserted the cycle after entering a write state.
  - ADR_O/DAT_O are held stable until ACK_I=1 is sampled.
  - STB_O/CYC_O deassert the cycle after ACK, giving at least one idle cycle between transfers.
  - Wait for ACK is unbounded.
  - First STB_O rises 1 cycle after the accept edge.
- ADVANCE:
  - If col < COLS-1: col+1 -> IDLE.
  - Else: col=0, row advance -> CLR_DATA for the new row.
- Row advance: row+1; row ROWS-1 wraps to 0. There is no scrolling.
- Row clear (CLR_DATA/CLR_COL/CLR_NEXT) over cells row*COLS .. row*COLS+COLS-1, in ascending order:
  - Per cell: write CLEAR_CHAR to data, then latched colour to colour.
  - After the last cell -> IDLE.
  - The cursor stays at (row,0).
- Screen clear covers cells 0..COLS*ROWS-1 (default 4800 cells, 9600 transfers), same per-cell write order, then -> IDLE with cursor 0,0.
- While busy, char_valid is ignored (char_ready=0); colour_in changes do not affect the operation in flight.
- cursor_col/cursor_row are registered and update at the transition edge.

Test Plan:
- Reset, ACK_I tied high, send 'A' (0x41), colour 0x1F -> ADR 0x2000 DAT 0x41, then ADR 0x4000 DAT 0x1F; cursor 0,1; char_ready returns high.
- Cursor at row 2 col 79, send 'Z' -> writes at idx 239 (ADR 0x20EF/0x40EF), then 80 clear pairs on idx 240..319 (0x20 plus colour); cursor row 3 col 0.
- Cursor at row 59 col 5, send 0x0A -> row 0 clear, idx 0..79 (160 transfers); cursor 0,0.
- Send 0x0D at col 40 and 0x08 at col 0 -> no STB_O pulse; col goes 40->0, and 0 stays 0.
- ACK_I delayed 3 cycles per transfer -> ADR_O/DAT_O stable until ACK; exactly 2 transfers per char; STB_O low at least 1 cycle between them.
- Send 0x0C, assert RST_I after 100 transfers -> STB_O low at the next edge, no further writes, cursor 0,0, char_ready=1 after release. INIT_CLEAR=1 -> 9600 transfers after reset before char_ready rises.

Source files
------------

// File: rtl/vga_text_console.sv
// Character-stream front end for the VGA text VRAM.
// Accepts bytes over valid/ready, tracks a hardware cursor and turns each byte
// into Wishbone write cycles to the data (ADR {2'b01,idx}) and colour
// (ADR {2'b10,idx}) windows, including line wrap, row clear and screen clear.
module vga_text_console #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 60,
    parameter int unsigned IDX_W      = 13,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20,
    parameter bit          INIT_CLEAR = 1'b0
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic [7:0]  colour_in,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic [14:0] ADR_O,
    output logic [7:0]  DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    localparam logic [IDX_W-1:0] COLS_W    = IDX_W'(COLS);
    localparam logic [IDX_W-1:0] ROW_SPAN  = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(COLS * ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [6:0]       LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]       LAST_ROW  = 6'(ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrCol,
        StAdvance,
        StClrData,
        StClrCol,
        StClrNext,
        StClrScreen
    } state_e;

    state_e           state_q;
    logic [6:0]       col_q;
    logic [5:0]       row_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;    // final cell index of the clear in progress
    logic [7:0]       char_q;
    logic [7:0]       attr_q;
    logic [14:0]      adr_q;
    logic [7:0]       dat_q;
    logic             cyc_q;
    logic             stb_q;
    logic             we_q;

    logic [5:0]       row_next;
    logic [IDX_W-1:0] row_next_base;
    logic [IDX_W-1:0] cur_idx;
    logic [14:0]      wr_adr;
    logic [7:0]       wr_dat;
    state_e           wr_next;

    // Cursor arithmetic: wrapped next row, its first cell, and the current cell.
    always_comb begin
        row_next      = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
        row_next_base = IDX_W'(row_next) * COLS_W;
        cur_idx       = IDX_W'(row_q) * COLS_W + IDX_W'(col_q);
    end

    // Address, data and follow-on state for whichever write state is active.
    always_comb begin
        wr_adr  = {2'b01, idx_q};
        wr_dat  = CLEAR_CHAR;
        wr_next = StClrCol;
        case (state_q)
            StWrData: begin
                wr_dat  = char_q;
                wr_next = StWrCol;
            end
            StWrCol: begin
                wr_adr  = {2'b10, idx_q};
                wr_dat  = attr_q;
                wr_next = StAdvance;
            end
            StClrCol: begin
                wr_adr  = {2'b10, idx_q};
                wr_dat  = attr_q;
                wr_next = StClrNext;
            end
            default: ;
        endcase
    end

    // Control FSM with registered cursor and Wishbone outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= INIT_CLEAR ? StClrScreen : StIdle;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            last_q  <= LAST_CELL;
            char_q  <= '0;
            attr_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (char_valid) begin
                        char_q <= char_data;
                        attr_q <= colour_in;
                        case (char_data)
                            8'h0D: col_q <= '0;
                            8'h08: col_q <= (col_q == 7'd0) ? 7'd0 : col_q - 7'd1;
                            8'h0A: begin
                                col_q   <= '0;
                                row_q   <= row_next;
                                idx_q   <= row_next_base;
                                last_q  <= row_next_base + ROW_SPAN;
                                state_q <= StClrData;
                            end
                            8'h0C: begin
                                col_q   <= '0;
                                row_q   <= '0;
                                idx_q   <= '0;
                                last_q  <= LAST_CELL;
                                state_q <= StClrScreen;
                            end
                            default: begin
                                idx_q   <= cur_idx;
                                state_q <= StWrData;
                            end
                        endcase
                    end
                end
                StAdvance: begin
                    if (col_q < LAST_COL) begin
                        col_q   <= col_q + 7'd1;
                        state_q <= StIdle;
                    end else begin
                        col_q   <= '0;
                        row_q   <= row_next;
                        idx_q   <= row_next_base;
                        last_q  <= row_next_base + ROW_SPAN;
                        state_q <= StClrData;
                    end
                end
                StClrNext: begin
                    if (idx_q == last_q) begin
                        state_q <= StIdle;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        state_q <= StClrData;
                    end
                end
                // Write states: raise the strobe one cycle after entry, hold
                // address/data until ACK, then drop for at least one cycle.
                default: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        cyc_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= wr_adr;
                        dat_q <= wr_dat;
                    end else if (ACK_I) begin
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= wr_next;
                    end
                end
            endcase
        end
    end

    assign char_ready = (state_q == StIdle) & ~RST_I;
    assign busy       = (state_q != StIdle);
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign ADR_O      = adr_q;
    assign DAT_O      = dat_q;
    assign CYC_O      = cyc_q;
    assign STB_O      = stb_q;
    assign WE_O       = we_q;

endmodule
